// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : datapath side; drives the hazard-detect inputs and receives the
//            enables, flushes and stall counter.
//   slave  : controller side.
// Signals:
//   id_rs, id_rt, id_uses_rt   register operands of the instruction in ID
//   idex_mem_read, idex_rt     load in ID/EX and its destination register
//   ex_branch_taken            taken branch resolved in EX
//   ex_muldiv_start            mult/div entering EX
//   mem_busy                   memory stage not ready
//   pc_we .. exmem_we          pipeline register write enables
//   ifid_flush, idex_flush     registered aload (bubble) controls
//   stall_cycles               saturating count of cycles with pc_we low
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             ex_branch_taken;
  logic             ex_muldiv_start;
  logic             mem_busy;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, ex_muldiv_start, mem_busy,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, ex_muldiv_start, mem_busy,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives the write enables (hold) and aload
// (flush/bubble) controls of the PC, IF/ID, ID/EX and EX/MEM registers.
// Handles load-use hazards, taken branches, fixed-latency mult/div occupancy
// and memory-stage busy, and counts stalled cycles.
// Ports:
//   clk       rising-edge clock
//   areset_n  asynchronous active-low reset
//   hz        hazard bundle (slave side), see pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  areset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned     MdW    = $clog2(MULDIV_LAT + 1);
  localparam bit              MdEn   = (MULDIV_LAT > 1);
  localparam logic [MdW-1:0]  MdLoad = MdW'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait, StMdWait} state_e;

  state_e           state_q, state_d;
  logic [MdW-1:0]   md_cnt_q, md_cnt_d;
  logic             ifid_flush_q, ifid_flush_d;
  logic             idex_flush_q, idex_flush_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;
  logic             pc_we, ifid_we, idex_we, exmem_we;

  // Register 0 is hard-wired, so a load to it never creates a dependency.
  assign load_use = hz.idex_mem_read && (hz.idex_rt != 5'd0) &&
                    ((hz.idex_rt == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.idex_rt == hz.id_rt)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    ifid_flush_d = 1'b0;
    idex_flush_d = 1'b0;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    exmem_we     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hz.mem_busy) begin
          state_d = StMemWait;
        end else if (hz.ex_branch_taken) begin
          // Branch target is loaded now; the two younger slots get bubbled.
          pc_we        = 1'b1;
          exmem_we     = 1'b1;
          ifid_flush_d = 1'b1;
          idex_flush_d = 1'b1;
          state_d      = StFlush;
        end else if (hz.ex_muldiv_start && MdEn) begin
          md_cnt_d = MdLoad;
          state_d  = StMdWait;
        end else if (load_use) begin
          // Load moves on to MEM, dependent instruction stays in IF/ID.
          exmem_we     = 1'b1;
          idex_flush_d = 1'b1;
          state_d      = StFlush;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
        end
      end
      StFlush: begin
        // Flush flags are high this cycle; no capture into cleared registers.
        exmem_we = 1'b1;
        state_d  = StRun;
      end
      StMemWait: begin
        // Release cycle has no enables; RUN re-evaluates next cycle.
        if (!hz.mem_busy) state_d = StRun;
      end
      StMdWait: begin
        if (md_cnt_q != '0) begin
          md_cnt_d = md_cnt_q - MdW'(1);
        end else if (!hz.mem_busy) begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          state_d  = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= StRun;
      md_cnt_q     <= '0;
      ifid_flush_q <= 1'b0;
      idex_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      ifid_flush_q <= ifid_flush_d;
      idex_flush_q <= idex_flush_d;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      stall_q <= '0;
    end else if (!pc_we && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Enables are gated by reset so nothing captures while it is asserted.
  assign hz.pc_we        = areset_n & pc_we;
  assign hz.ifid_we      = areset_n & ifid_we;
  assign hz.idex_we      = areset_n & idex_we;
  assign hz.exmem_we     = areset_n & exmem_we;
  assign hz.ifid_flush   = ifid_flush_q;
  assign hz.idex_flush   = idex_flush_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (16-bit and 4-bit stall counter)
// share one stimulus stream; a schedule-queue model predicts every output.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned Lat = 4;

  // Future-cycle schedule entries of the model.
  localparam int EBr   = 0; // branch bubble cycle
  localparam int ELu   = 1; // load-use bubble cycle
  localparam int EHold = 2; // mult/div busy cycle
  localparam int EEnd  = 3; // mult/div done, waits for memory
  localparam int EMem  = 4; // memory busy wait / release

  logic       clk = 1'b0;
  logic       areset_n;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_mem_read, ex_branch_taken, ex_muldiv_start, mem_busy;

  int vecs  = 0;
  int fails = 0;
  int sched[$];
  int model_cnt = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz_main ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hz_small ();

  assign hz_main.id_rs            = id_rs;
  assign hz_main.id_rt            = id_rt;
  assign hz_main.id_uses_rt       = id_uses_rt;
  assign hz_main.idex_mem_read    = idex_mem_read;
  assign hz_main.idex_rt          = idex_rt;
  assign hz_main.ex_branch_taken  = ex_branch_taken;
  assign hz_main.ex_muldiv_start  = ex_muldiv_start;
  assign hz_main.mem_busy         = mem_busy;
  assign hz_small.id_rs           = id_rs;
  assign hz_small.id_rt           = id_rt;
  assign hz_small.id_uses_rt      = id_uses_rt;
  assign hz_small.idex_mem_read   = idex_mem_read;
  assign hz_small.idex_rt         = idex_rt;
  assign hz_small.ex_branch_taken = ex_branch_taken;
  assign hz_small.ex_muldiv_start = ex_muldiv_start;
  assign hz_small.mem_busy        = mem_busy;

  pipeline_hazard_ctrl #(.MULDIV_LAT(Lat), .CNT_W(16)) dut_main (
    .clk      (clk),
    .areset_n (areset_n),
    .hz       (hz_main)
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(Lat), .CNT_W(4)) dut_small (
    .clk      (clk),
    .areset_n (areset_n),
    .hz       (hz_small)
  );

  always #5 clk = ~clk;

  wire [3:0] we_main  = {hz_main.pc_we, hz_main.ifid_we, hz_main.idex_we, hz_main.exmem_we};
  wire [3:0] we_small = {hz_small.pc_we, hz_small.ifid_we, hz_small.idex_we, hz_small.exmem_we};
  wire [1:0] fl_main  = {hz_main.ifid_flush, hz_main.idex_flush};
  wire [1:0] fl_small = {hz_small.ifid_flush, hz_small.idex_flush};

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle model and compare, sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic [3:0] we_e;
    logic [1:0] fl_e;
    bit         lu;
    we_e = 4'h0;
    fl_e = 2'b00;
    if (!areset_n) begin
      sched.delete();
      model_cnt = 0;
    end else begin
      lu = idex_mem_read && (idex_rt != 0) &&
           ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
      if (sched.size() == 0) begin
        if (mem_busy) begin
          sched.push_back(EMem);
        end else if (ex_branch_taken) begin
          we_e = 4'b1001;
          sched.push_back(EBr);
        end else if (ex_muldiv_start && Lat > 1) begin
          for (int i = 0; i < int'(Lat) - 2; i++) sched.push_back(EHold);
          sched.push_back(EEnd);
        end else if (lu) begin
          we_e = 4'b0001;
          sched.push_back(ELu);
        end else begin
          we_e = 4'hF;
        end
      end else begin
        case (sched[0])
          EBr:   begin we_e = 4'b0001; fl_e = 2'b11; void'(sched.pop_front()); end
          ELu:   begin we_e = 4'b0001; fl_e = 2'b01; void'(sched.pop_front()); end
          EHold: void'(sched.pop_front());
          EEnd:  if (!mem_busy) begin we_e = 4'hF; void'(sched.pop_front()); end
          default: if (!mem_busy) void'(sched.pop_front());
        endcase
      end
    end
    chk("we_main", we_main, we_e);
    chk("we_small", we_small, we_e);
    chk("flush_main", fl_main, fl_e);
    chk("flush_small", fl_small, fl_e);
    chk("stall_main", hz_main.stall_cycles, (model_cnt > 65535) ? 65535 : model_cnt);
    chk("stall_small", hz_small.stall_cycles, (model_cnt > 15) ? 15 : model_cnt);
    if (areset_n && !we_e[3]) model_cnt++;
  end

  initial begin
    areset_n = 1'b0;
    id_rs = '0; id_rt = '0; idex_rt = '0;
    id_uses_rt = 1'b0; idex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0; mem_busy = 1'b0;
    cyc();
    cyc();
    areset_n = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    chk("idle_we", we_main, 4'hF);
    chk("idle_flush", fl_main, 2'b00);
    chk("idle_stall", hz_main.stall_cycles, 0);

    // Load-use on rs.
    cyc(); idex_mem_read = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    @(negedge clk); chk("lu_t_we", we_main, 4'b0001);
    cyc(); idex_mem_read = 1'b0; idex_rt = '0; id_rs = '0;
    @(negedge clk); chk("lu_t1_flush", fl_main, 2'b01); chk("lu_t1_we", we_main, 4'b0001);
    cyc();
    @(negedge clk); chk("lu_t2_we", we_main, 4'hF); chk("lu_stall", hz_main.stall_cycles, 2);

    // Load to r0: no stall.
    cyc(); idex_mem_read = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk); chk("lu_r0_we", we_main, 4'hF);
    cyc(); idex_mem_read = 1'b0;
    @(negedge clk); chk("lu_r0_stall", hz_main.stall_cycles, 2);

    // Taken branch.
    cyc(); ex_branch_taken = 1'b1;
    @(negedge clk); chk("br_t_we", we_main, 4'b1001);
    cyc(); ex_branch_taken = 1'b0;
    @(negedge clk); chk("br_t1_flush", fl_main, 2'b11); chk("br_t1_we", we_main, 4'b0001);
    cyc();
    @(negedge clk); chk("br_t2_we", we_main, 4'hF); chk("br_stall", hz_main.stall_cycles, 3);

    // Mult/div, memory idle.
    cyc(); ex_muldiv_start = 1'b1;
    @(negedge clk); chk("md_t0", we_main, 4'h0);
    cyc(); ex_muldiv_start = 1'b0;
    @(negedge clk); chk("md_t1", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("md_t2", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("md_t3", we_main, 4'hF); chk("md_stall", hz_main.stall_cycles, 6);

    // Mult/div with memory busy through the completion cycle.
    cyc(); ex_muldiv_start = 1'b1;
    @(negedge clk); chk("mdm_t0", we_main, 4'h0);
    cyc(); ex_muldiv_start = 1'b0;
    @(negedge clk); chk("mdm_t1", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("mdm_t2", we_main, 4'h0);
    cyc(); mem_busy = 1'b1;
    @(negedge clk); chk("mdm_t3", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("mdm_t4", we_main, 4'h0);
    cyc(); mem_busy = 1'b0;
    @(negedge clk); chk("mdm_t5", we_main, 4'hF); chk("mdm_stall", hz_main.stall_cycles, 11);

    // Branch and mem_busy together, then reset during the flush cycle.
    cyc(); ex_branch_taken = 1'b1; mem_busy = 1'b1;
    @(negedge clk); chk("bm_t0", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("bm_t1", we_main, 4'h0);
    cyc(); mem_busy = 1'b0;
    @(negedge clk); chk("bm_release", we_main, 4'h0);
    cyc();
    @(negedge clk); chk("bm_branch", we_main, 4'b1001);
    cyc(); ex_branch_taken = 1'b0;
    @(negedge clk); chk("bm_flush", fl_main, 2'b11);
    #1 areset_n = 1'b0;
    #1;
    chk("rst_flush_drop", fl_main, 2'b00);
    chk("rst_we_zero", we_main, 4'h0);
    chk("rst_stall_clr", hz_main.stall_cycles, 0);
    cyc();
    cyc();
    areset_n = 1'b1;

    // Saturation of the 4-bit counter.
    cyc(); mem_busy = 1'b1;
    repeat (19) cyc();
    cyc(); mem_busy = 1'b0;
    cyc();
    @(negedge clk);
    chk("sat_small", hz_small.stall_cycles, 15);
    chk("sat_main", hz_main.stall_cycles, 21);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      cyc();
      areset_n        = ($urandom_range(0, 99) != 0);
      mem_busy        = ($urandom_range(0, 99) < 15);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      ex_muldiv_start = ($urandom_range(0, 99) < 10);
      idex_mem_read   = ($urandom_range(0, 99) < 40);
      id_uses_rt      = $urandom_range(0, 1) != 0;
      idex_rt         = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
    end
    cyc();
    areset_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control side of the stage pipeline registers; drives each register's write_enable (hold) and aload (flush/bubble) inputs.
- Detects four conditions:
  - load-use data hazards in ID;
  - taken branches resolved in EX;
  - fixed-latency mult/div occupancy in EX;
  - memory-stage busy.
- Generates hold, flush and bubble sequencing for PC, IF/ID, ID/EX and EX/MEM, and keeps a saturating stall-cycle counter.

Parameters:
- MULDIV_LAT, 4, cycles a mult/div occupies EX (>=1).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination of load in ID/EX.
- ex_branch_taken  in  1  branch in EX resolved taken (PC mux selects target this cycle).
- ex_muldiv_start  in  1  mult/div entering EX this cycle.
- mem_busy  in  1  memory stage not ready; freeze pipeline.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write_enable.
- idex_we  out  1  ID/EX write_enable.
- exmem_we  out  1  EX/MEM write_enable.
- ifid_flush  out  1  IF/ID aload, registered.
- idex_flush  out  1  ID/EX aload, registered.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.

Behaviour:
- Reset (areset_n low, async):
  - state=RUN, md_cnt=0, ifid_flush=idex_flush=0, stall_cycles=0.
  - All *_we forced 0 while reset is asserted.
- States: RUN, FLUSH, MEM_WAIT, MD_WAIT.
- *_we outputs are combinational from state and inputs. Flush outputs come directly from flops, so they are glitch-free.
- Flush cycle rule: whenever ifid_flush or idex_flush=1, pc_we=ifid_we=idex_we=0. The edge ending the flush cycle never captures into a register being cleared.
- Load-use hazard (LU) = idex_mem_read & idex_rt!=0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
- RUN priority: mem_busy > ex_branch_taken > (ex_muldiv_start & MULDIV_LAT>1) > LU > normal.
  - mem_busy: all we=0; next MEM_WAIT.
  - branch: pc_we=1, exmem_we=1, ifid_we=idex_we=0; next FLUSH with ifid_flush=idex_flush=1.
  - muldiv: all we=0; md_cnt<=MULDIV_LAT-2; next MD_WAIT.
  - LU: pc_we=ifid_we=idex_we=0, exmem_we=1; next FLUSH with idex_flush=1 only. The load advances; the dependent instruction is held in IF/ID.
  - normal: all we=1; stay RUN.
- FLUSH (exactly 1 cycle): flush flags as latched; pc/ifid/idex we=0, exmem_we=1.
  - Next state is RUN and both flush flags clear. This holds even if mem_busy is asserted during FLUSH; mem_busy is then honoured in RUN.
  - Branch penalty and LU penalty are both 2 cycles.
- MEM_WAIT: all we=0 while mem_busy=1. On mem_busy=0, go to RUN with no enables this cycle; RUN re-evaluates all conditions next cycle.
- MD_WAIT: md_cnt decrements each cycle; all we=0 while md_cnt>0.
  - At md_cnt==0 with mem_busy=0: all we=1; next RUN.
  - At md_cnt==0 with mem_busy=1: hold md_cnt at 0 with all we=0.
  - ex_branch_taken and LU are ignored in MD_WAIT; their inputs are frozen and get re-evaluated in RUN.
- MULDIV_LAT=1: ex_muldiv_start has no effect.
- stall_cycles:
  - Increments at each edge where pc_we==0 and reset is deasserted.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Reset mid-operation: returns immediately to RUN; pending flush flags and md_cnt are cleared.
- Register 0 never causes a stall.

Test Plan:
- Reset, then idle with no hazards -> all we=1, flushes 0, stall_cycles=0 after 10 cycles.
- idex_mem_read=1, idex_rt=5, id_rs=5 -> cycle t: pc/ifid/idex we=0, exmem_we=1; t+1: idex_flush=1 only; t+2: all we=1; stall_cycles=2. Repeat with idex_rt=0 -> no stall.
- ex_branch_taken=1 for one cycle -> t: pc_we=1, exmem_we=1, ifid/idex we=0; t+1: ifid_flush=idex_flush=1; t+2: RUN.
- ex_muldiv_start with MULDIV_LAT=4 -> all we=0 for 3 cycles, all we=1 on 4th; stall_cycles=3. With mem_busy high through the 4th cycle, enables stay 0 until it drops.
- Branch and mem_busy asserted together -> mem_busy wins (MEM_WAIT); after release RUN re-detects branch and flushes; areset_n pulsed during FLUSH -> flush outputs drop immediately.
- CNT_W=4, hold mem_busy for 20 cycles -> stall_cycles saturates at 15.
